midi_poly_tx: RTL



---
 rtl/midi_poly_tx.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/midi_poly_tx.sv
// Polyphonic MIDI transmitter: turns key level changes and instrument changes into
// Note On/Off and Program Change messages with running status, sent as 8N1 serial.
module midi_poly_tx #(
    parameter int NKEYS          = 10,
    parameter int CLK_HZ         = 50000000,
    parameter int BAUD           = 31250,
    parameter int BASE_NOTE      = 60,
    parameter int CHANNEL        = 0,
    parameter int RUNNING_STATUS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [NKEYS-1:0] key,
    input  logic [4:0]       pitchshift,
    input  logic [6:0]       volume,
    input  logic [6:0]       program_num,
    output logic             tx,
    output logic             busy
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int IW      = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam logic [3:0] CH = 4'(CHANNEL);

    typedef enum logic [1:0] {S_IDLE, S_PICK, S_SEND} state_t;

    state_t            state, state_nx;
    logic [NKEYS-1:0]  key_q, sounding, pend;
    logic [6:0]        note_lat [NKEYS];
    logic [6:0]        prog_last;
    logic              prog_valid;
    logic [7:0]        last_status;
    logic              status_valid;
    logic [7:0]        msg [3];
    logic [1:0]        msg_len, byte_idx;
    logic [9:0]        frame;
    logic [3:0]        bit_cnt;
    logic [CW-1:0]     cyc_cnt;
    logic              busy_q;

    logic              prog_pend, any_pend, key_found, is_press, three, omit;
    logic [IW-1:0]     pick_idx;
    logic [8:0]        note_sum;
    logic [6:0]        note_new;
    logic [7:0]        status, d1, d2, m0, m1, m2;
    logic [1:0]        nx_len;
    logic              bit_end, frame_end, msg_end;

    assign prog_pend = ena && (!prog_valid || program_num != prog_last);
    assign pend      = ena ? (key_q ^ sounding) : sounding;
    assign any_pend  = prog_pend || (|pend);

    // Lowest-index pending key wins: scan downward so the last hit is the lowest.
    always_comb begin
        key_found = 1'b0;
        pick_idx  = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                key_found = 1'b1;
                pick_idx  = IW'(i);
            end
        end
    end

    assign note_sum = 9'(BASE_NOTE) + 9'(pick_idx) + {{4{pitchshift[4]}}, pitchshift};
    assign note_new = note_sum[8] ? 7'd0 : (note_sum[7] ? 7'h7f : note_sum[6:0]);
    assign is_press = ena && key_q[pick_idx];

    always_comb begin
        status = 8'h00;
        d1     = 8'h00;
        d2     = 8'h00;
        three  = 1'b0;
        if (prog_pend) begin
            status = {4'hC, CH};
            d1     = {1'b0, program_num};
        end else if (is_press) begin
            status = {4'h9, CH};
            d1     = {1'b0, note_new};
            d2     = {1'b0, volume};
            three  = 1'b1;
        end else begin
            status = {4'h8, CH};
            d1     = {1'b0, note_lat[pick_idx]};
            d2     = 8'h40;
            three  = 1'b1;
        end
        omit = (RUNNING_STATUS != 0) && status_valid && (status == last_status);
        if (omit) begin
            m0     = d1;
            m1     = d2;
            m2     = 8'h00;
            nx_len = three ? 2'd2 : 2'd1;
        end else begin
            m0     = status;
            m1     = d1;
            m2     = d2;
            nx_len = three ? 2'd3 : 2'd2;
        end
    end

    assign bit_end   = (cyc_cnt == CW'(BIT_CYC - 1));
    assign frame_end = bit_end && (bit_cnt == 4'd9);
    assign msg_end   = frame_end && (byte_idx == msg_len - 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (any_pend) state_nx = S_PICK;
            S_PICK:  state_nx = any_pend ? S_SEND : S_IDLE;
            S_SEND:  if (msg_end) state_nx = any_pend ? S_PICK : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q        <= '0;
            sounding     <= '0;
            // NOTE: note_lat is reset so a Note Off can never carry a stale note after reset.
            for (int i = 0; i < NKEYS; i++) note_lat[i] <= 7'd0;
            prog_last    <= 7'd0;
            prog_valid   <= 1'b0;
            last_status  <= 8'h00;
            status_valid <= 1'b0;
            for (int i = 0; i < 3; i++) msg[i] <= 8'h00;
            msg_len      <= 2'd0;
            byte_idx     <= 2'd0;
            frame        <= '1;
            bit_cnt      <= 4'd0;
            cyc_cnt      <= '0;
            busy_q       <= 1'b0;
        end else begin
            key_q <= key;
            case (state)
                S_PICK: begin
                    if (any_pend) begin
                        msg[0]       <= m0;
                        msg[1]       <= m1;
                        msg[2]       <= m2;
                        msg_len      <= nx_len;
                        byte_idx     <= 2'd0;
                        frame        <= {1'b1, m0, 1'b0};
                        bit_cnt      <= 4'd0;
                        cyc_cnt      <= '0;
                        busy_q       <= 1'b1;
                        last_status  <= status;
                        status_valid <= 1'b1;
                        if (prog_pend) begin
                            prog_last  <= program_num;
                            prog_valid <= 1'b1;
                        end else if (is_press) begin
                            note_lat[pick_idx] <= note_new;
                            sounding[pick_idx] <= 1'b1;
                        end else if (key_found) begin
                            sounding[pick_idx] <= 1'b0;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            if (!msg_end) begin
                                byte_idx <= byte_idx + 2'd1;
                                frame    <= {1'b1, msg[byte_idx + 2'd1], 1'b0};
                                bit_cnt  <= 4'd0;
                            end else begin
                                busy_q <= any_pend;
                            end
                        end else begin
                            frame   <= {1'b1, frame[9:1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx   = (state == S_SEND) ? frame[0] : 1'b1;
    assign busy = busy_q;

endmodule
